// File: rtl/time_display_scanner_pkg.sv
// Shared constants, segment table and converter state type for the time display scanner.
package time_display_pkg;

  localparam int NUM_DIGITS = 6;

  localparam logic [5:0] HOURS_MAX   = 6'd23;
  localparam logic [5:0] MIN_SEC_MAX = 6'd59;

  // Segment patterns are {g,f,e,d,c,b,a}, 1 = lit.
  localparam logic [6:0] SEG_LUT [10] = '{
    7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
    7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111
  };
  localparam logic [6:0] SEG_DASH  = 7'b1000000;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  typedef enum logic [2:0] {
    IDLE,
    CONV_H,
    CONV_M,
    CONV_S,
    COMMIT
  } conv_state_t;

  function automatic logic [6:0] seg_of(input logic [3:0] digit);
    return (digit <= 4'd9) ? SEG_LUT[digit] : SEG_BLANK;
  endfunction

endpackage

// File: rtl/time_display_scanner_bin2bcd.sv
// Single-field binary to BCD converter: subtracts 10 once per cycle until the value is below 10.
module bin2bcd_seq (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [5:0] value,
  output logic       done,
  output logic [2:0] tens,
  output logic [3:0] units
);

  logic [5:0] work_reg;
  logic [2:0] tens_reg;
  logic       busy_reg;

  // A start while busy reloads, so back-to-back fields need no idle cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      work_reg <= '0;
      tens_reg <= '0;
      busy_reg <= 1'b0;
    end else if (start) begin
      work_reg <= value;
      tens_reg <= '0;
      busy_reg <= 1'b1;
    end else if (busy_reg) begin
      if (work_reg >= 6'd10) begin
        work_reg <= work_reg - 6'd10;
        tens_reg <= tens_reg + 3'd1;
      end else begin
        busy_reg <= 1'b0;
      end
    end
  end

  assign done  = busy_reg && (work_reg < 6'd10);
  assign tens  = tens_reg;
  assign units = work_reg[3:0];

endmodule

// File: rtl/time_display_scanner.sv
// Six-digit multiplexed seven-segment scanner for HH MM SS with per-frame snapshot and guard cycles.
module time_display_scanner
  import time_display_pkg::*;
#(
  parameter int DIGIT_PERIOD = 50000,
  parameter int GUARD        = 4,
  parameter bit ACTIVE_LOW   = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] hours,
  input  logic [5:0] minutes,
  input  logic [5:0] seconds,
  output logic [6:0] seg,
  output logic       dp,
  output logic [5:0] dig_en,
  output logic       frame_err,
  output logic [6:0] seg_oeb,
  output logic [5:0] dig_oeb,
  output logic       dp_oeb
);

  localparam int DIV_W = $clog2(DIGIT_PERIOD);

  logic [DIV_W-1:0] div_reg;
  logic [2:0]       idx_reg;
  logic             tick;
  logic             frame_start;
  logic [5:0]       snap_h_reg, snap_m_reg, snap_s_reg;
  logic             snap_err;
  conv_state_t      state_reg, state_next;
  logic             conv_start, conv_done;
  logic [5:0]       conv_value;
  logic [2:0]       conv_tens;
  logic [3:0]       conv_units;
  logic [3:0]       bcd_reg  [NUM_DIGITS];
  logic [3:0]       disp_reg [NUM_DIGITS];
  logic             disp_err_reg;
  logic [NUM_DIGITS-1:0][6:0] digit_seg;
  logic [6:0]       seg_reg;
  logic             dp_reg;
  logic [5:0]       dig_en_reg;

  assign tick        = (div_reg == DIV_W'(DIGIT_PERIOD - 1));
  assign frame_start = tick && (idx_reg == 3'd5);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_reg <= '0;
      idx_reg <= '0;
    end else if (tick) begin
      div_reg <= '0;
      idx_reg <= (idx_reg == 3'd5) ? 3'd0 : idx_reg + 3'd1;
    end else begin
      div_reg <= div_reg + DIV_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      snap_h_reg <= '0;
      snap_m_reg <= '0;
      snap_s_reg <= '0;
      state_reg  <= IDLE;
    end else begin
      state_reg <= state_next;
      if (frame_start) begin
        snap_h_reg <= hours;
        snap_m_reg <= minutes;
        snap_s_reg <= seconds;
      end
    end
  end

  // Hours are fed from the live input on frame start: it is the value being snapshotted on the same edge.
  always_comb begin
    state_next = state_reg;
    conv_start = 1'b0;
    conv_value = '0;
    case (state_reg)
      CONV_H: if (conv_done) begin
        state_next = CONV_M;
        conv_start = 1'b1;
        conv_value = snap_m_reg;
      end
      CONV_M: if (conv_done) begin
        state_next = CONV_S;
        conv_start = 1'b1;
        conv_value = snap_s_reg;
      end
      CONV_S: if (conv_done) state_next = COMMIT;
      COMMIT: state_next = IDLE;
      default: ;
    endcase
    if (frame_start) begin
      state_next = CONV_H;
      conv_start = 1'b1;
      conv_value = hours;
    end
  end

  bin2bcd_seq u_conv (
    .clk   (clk),
    .reset (reset),
    .start (conv_start),
    .value (conv_value),
    .done  (conv_done),
    .tens  (conv_tens),
    .units (conv_units)
  );

  assign snap_err = (snap_h_reg > HOURS_MAX) || (snap_m_reg > MIN_SEC_MAX) ||
                    (snap_s_reg > MIN_SEC_MAX);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        bcd_reg[i]  <= '0;
        disp_reg[i] <= '0;
      end
      disp_err_reg <= 1'b0;
    end else begin
      if (conv_done) begin
        case (state_reg)
          CONV_H: begin bcd_reg[0] <= {1'b0, conv_tens}; bcd_reg[1] <= conv_units; end
          CONV_M: begin bcd_reg[2] <= {1'b0, conv_tens}; bcd_reg[3] <= conv_units; end
          CONV_S: begin bcd_reg[4] <= {1'b0, conv_tens}; bcd_reg[5] <= conv_units; end
          default: ;
        endcase
      end
      if (state_reg == COMMIT) begin
        for (int i = 0; i < NUM_DIGITS; i++) disp_reg[i] <= bcd_reg[i];
        disp_err_reg <= snap_err;
      end
    end
  end

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit_seg
    assign digit_seg[gi] = seg_of(disp_reg[gi]);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      seg_reg    <= '0;
      dp_reg     <= 1'b0;
      dig_en_reg <= '0;
    end else begin
      dig_en_reg <= (div_reg < DIV_W'(GUARD)) ? 6'd0 : (6'd1 << idx_reg);
      seg_reg    <= disp_err_reg ? SEG_DASH : digit_seg[idx_reg];
      dp_reg     <= ((idx_reg == 3'd1) || (idx_reg == 3'd3)) && !snap_s_reg[0];
    end
  end

  assign seg       = seg_reg ^ {7{ACTIVE_LOW}};
  assign dp        = dp_reg ^ ACTIVE_LOW;
  assign dig_en    = dig_en_reg ^ {6{ACTIVE_LOW}};
  assign frame_err = disp_err_reg;
  assign seg_oeb   = '0;
  assign dig_oeb   = '0;
  assign dp_oeb    = 1'b0;

endmodule
